// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the binary-to-BCD scanned display driver.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BLANK_NIB = 4'hF;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal digits needed to hold the largest value of a 'bits'-wide source.
  function automatic int dec_digits(input int bits);
    int max_val;
    int n;
    max_val = (1 << bits) - 1;
    n = 1;
    while (pow10(n) <= max_val) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/bin_bcd_scan_display_if.sv
// Control, source and display signals of the BCD scan display driver.
interface bin_bcd_scan_display_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  en;
  logic                  start;
  logic [BIN_W-1:0]      src_x;
  logic [BIN_W-1:0]      src_y;
  logic [BIN_W-1:0]      src_z;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     dig_sel;
  logic [3:0]            dig_val;

  modport master (
    output en, start, src_x, src_y, src_z,
    input  busy, done, overflow, bcd, dig_sel, dig_val
  );

  modport slave (
    input  en, start, src_x, src_y, src_z,
    output busy, done, overflow, bcd, dig_sel, dig_val
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// Digit scan: free-running prescaler, digit index and registered select/value mux.
// Optional leading-zero blanking under BCD_LEADING_ZERO_BLANK_EN.
module bcd_scan_mux
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIGITS*NIB_W-1:0] bcd,
  output logic [DIGITS-1:0]       dig_sel,
  output logic [NIB_W-1:0]        dig_val
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PS_W-1:0]   ps;
  logic [IDX_W-1:0]  idx;
  logic              wrap;
  logic              blank;
  logic [NIB_W-1:0]  nib;
  logic [DIGITS-1:0] sel_nxt;
  logic [NIB_W-1:0]  val_nxt;

  assign wrap = (ps == PS_LAST);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Digit 0 is never above msd, so a zero value still shows one "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[i*NIB_W +: NIB_W] != '0) msd = IDX_W'(i);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    nib     = '0;
    sel_nxt = '0;
    val_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) nib = bcd[i*NIB_W +: NIB_W];
    end
    if (en) begin
      if (blank) begin
        val_nxt = BLANK_NIB;
      end else begin
        sel_nxt = DIGITS'(1) << idx;
        val_nxt = nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps      <= '0;
      idx     <= '0;
      dig_sel <= '0;
      dig_val <= '0;
    end else begin
      ps <= wrap ? '0 : ps + 1'b1;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      dig_sel <= sel_nxt;
      dig_val <= val_nxt;
    end
  end

endmodule

// File: rtl/bin_bcd_scan_display.sv
// Priority source select, sequential double-dabble conversion and scanned digit output.
// Build option: BCD_LEADING_ZERO_BLANK_EN enables leading-zero blanking in the scan mux.
module bin_bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  bin_bcd_scan_display_if.slave bus
);

  // The accumulator covers the full source range so overflow is exact even
  // when BIN_W needs more than DIGITS+1 decimal digits.
  localparam int SRC_DIG = dec_digits(BIN_W);
  localparam int ACC_NIB = (SRC_DIG > DIGITS + 1) ? SRC_DIG : DIGITS + 1;
  localparam int ACC_W   = ACC_NIB * NIB_W;
  localparam int BCD_W   = DIGITS * NIB_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
    $error("BIN_W must be 1..16");
  end
  if (DIGITS < 1 || pow10(DIGITS) > pow10(5)) begin : g_bad_digits
    $error("DIGITS must be 1..5");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 1");
  end

  conv_state_e      state;
  conv_state_e      state_nxt;
  logic [BIN_W-1:0] src_sel;
  logic [BIN_W-1:0] sr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_adj;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_sat;
  logic             acc_ovf;
  logic             ovf_q;
  logic             done_q;
  logic             load;
  logic             shift;
  logic             finish;
  logic [DIGITS-1:0] dig_sel;
  logic [NIB_W-1:0]  dig_val;

  always_comb begin
    if (bus.src_x != '0)      src_sel = bus.src_x;
    else if (bus.src_y != '0) src_sel = bus.src_y;
    else                      src_sel = bus.src_z;
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < ACC_NIB; i++) begin
      if (acc[i*NIB_W +: NIB_W] >= 4'd5)
        acc_adj[i*NIB_W +: NIB_W] = acc[i*NIB_W +: NIB_W] + 4'd3;
    end
  end

  assign acc_ovf = |acc[ACC_W-1:BCD_W];
  assign bcd_sat = acc_ovf ? {DIGITS{4'h9}} : acc[BCD_W-1:0];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (load) begin
        sr  <= src_sel;
        acc <= '0;
        cnt <= '0;
      end
      if (shift) begin
        acc <= (acc_adj << 1) | ACC_W'(sr[BIN_W-1]);
        sr  <= sr << 1;
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        bcd_q <= bcd_sat;
        ovf_q <= acc_ovf;
      end
    end
  end

  bcd_scan_mux #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .bcd     (bcd_q),
    .dig_sel (dig_sel),
    .dig_val (dig_val)
  );

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
  assign bus.dig_sel  = dig_sel;
  assign bus.dig_val  = dig_val;

endmodule

// File: tb/tb_bin_bcd_scan_display.sv
// Directed bench: a 3-digit and a 2-digit instance driven with identical stimulus.
module tb_bin_bcd_scan_display;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] model3 = '0;
  logic [7:0]  model2 = '0;

  always #5 clk = ~clk;

  bin_bcd_scan_display_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin_bcd_scan_display_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  bin_bcd_scan_display #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk (clk), .rst (rst), .bus (b3)
  );
  bin_bcd_scan_display #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk (clk), .rst (rst), .bus (b2)
  );

  task automatic drive(input logic en, input logic st, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] z);
    b3.en = en; b3.start = st; b3.src_x = x; b3.src_y = y; b3.src_z = z;
    b2.en = en; b2.start = st; b2.src_x = x; b2.src_y = y; b2.src_z = z;
  endtask

  // Expected {dig_sel, dig_val} of the 3-digit instance while digit d is scanned.
  function automatic logic [6:0] exp_scan(input logic [11:0] v, input int d);
    int msd;
    msd = 0;
    if (v[7:4] != 0)  msd = 1;
    if (v[11:8] != 0) msd = 2;
    if (BLANK_ON && d > msd) return {3'b000, 4'hF};
    return {3'(1 << d), 4'((v >> (4 * d)) & 12'hF)};
  endfunction

  task automatic wait_slot0(output bit ok);
    logic [2:0] prev;
    ok   = 1'b0;
    prev = b3.dig_sel;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (prev != 3'b001 && b3.dig_sel == 3'b001) ok = 1'b1;
      prev = b3.dig_sel;
    end
  endtask

  task automatic convert(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                         input logic [11:0] e3, input logic e3o,
                         input logic [7:0] e2, input logic e2o, input string nm);
    drive(b3.en, 1'b1, x, y, z);
    @(negedge clk);
    drive(b3.en, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if ({b3.busy, b3.done, b3.bcd} !== {1'b1, 1'b0, model3}) begin
        errors++;
        $display("FAIL %s_busy[%0d]: busy=%b done=%b bcd=%h, want busy=1 done=0 bcd=%h",
                 nm, k, b3.busy, b3.done, b3.bcd, model3);
      end
      @(negedge clk);
    end
    checks++;
    if ({b3.busy, b3.done, b3.bcd, b3.overflow} !== {1'b0, 1'b1, e3, e3o}) begin
      errors++;
      $display("FAIL %s_done3: busy=%b done=%b bcd=%h ovf=%b, want 0 1 %h %b",
               nm, b3.busy, b3.done, b3.bcd, b3.overflow, e3, e3o);
    end
    checks++;
    if ({b2.done, b2.bcd, b2.overflow} !== {1'b1, e2, e2o}) begin
      errors++;
      $display("FAIL %s_done2: done=%b bcd=%h ovf=%b, want 1 %h %b",
               nm, b2.done, b2.bcd, b2.overflow, e2, e2o);
    end
    model3 = e3;
    model2 = e2;
    @(negedge clk);
    checks++;
    if ({b3.done, b2.done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_pulse: done3=%b done2=%b, want 0 0", nm, b3.done, b2.done);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'd9, 8'd0, 8'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({b3.busy, b3.done, b3.overflow, b3.bcd, b3.dig_sel, b3.dig_val} !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: busy=%b done=%b bcd=%h sel=%b val=%h, want all 0",
                 k, b3.busy, b3.done, b3.bcd, b3.dig_sel, b3.dig_val);
      end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd9, 8'd0, 8'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({b3.busy, b3.done, b3.bcd} !== '0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b bcd=%h, want 0 0 000",
                 k, b3.busy, b3.done, b3.bcd);
      end
    end
  endtask

  task automatic test_convert();
    convert(8'd0, 8'd57, 8'd3, 12'h057, 1'b0, 8'h57, 1'b0, "conv57");
    convert(8'd200, 8'd57, 8'd3, 12'h200, 1'b0, 8'h99, 1'b1, "conv200");
    convert(8'd0, 8'd0, 8'd3, 12'h003, 1'b0, 8'h03, 1'b0, "conv_z");
  endtask

  task automatic test_overflow();
    convert(8'd255, 8'd0, 8'd0, 12'h255, 1'b0, 8'h99, 1'b1, "conv255");
    convert(8'd0, 8'd0, 8'd0, 12'h000, 1'b0, 8'h00, 1'b0, "conv0");
  endtask

  task automatic test_scan();
    bit ok;
    logic [6:0] e;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    convert(8'd123, 8'd0, 8'd0, 12'h123, 1'b0, 8'h99, 1'b1, "conv123");
    wait_slot0(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan123_sync: digit 0 slot not seen within 40 cycles, sel=%b", b3.dig_sel);
    end
    for (int k = 0; k < 16; k++) begin
      e = exp_scan(12'h123, (k / 4) % 3);
      checks++;
      if ({b3.dig_sel, b3.dig_val} !== e) begin
        errors++;
        $display("FAIL scan123[%0d]: sel=%b val=%h, want sel=%b val=%h",
                 k, b3.dig_sel, b3.dig_val, e[6:4], e[3:0]);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    checks++;
    if ({b3.dig_sel, b3.dig_val, b2.dig_sel, b2.dig_val} !== '0) begin
      errors++;
      $display("FAIL en_drop: sel=%b val=%h, want 000 0", b3.dig_sel, b3.dig_val);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int at;
    ndone = 0;
    at    = -1;
    drive(1'b0, 1'b1, 8'd45, 8'd0, 8'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k < 24; k++) begin
      if (k == 3) drive(1'b0, 1'b1, 8'd200, 8'd0, 8'd0);
      if (k == 4) drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      if (b3.done) begin
        ndone++;
        at = k;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1 || at != 10) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d at sample %0d, want 1 at sample 10", ndone, at);
    end
    checks++;
    if ({b3.bcd, b3.busy, b2.bcd} !== {12'h045, 1'b0, 8'h45}) begin
      errors++;
      $display("FAIL b2b_bcd: bcd3=%h busy=%b bcd2=%h, want 045 0 45", b3.bcd, b3.busy, b2.bcd);
    end
    model3 = 12'h045;
    model2 = 8'h45;
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    drive(1'b0, 1'b1, 8'd77, 8'd0, 8'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({b3.busy, b3.done, b3.overflow, b3.bcd, b2.bcd} !== '0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b ovf=%b bcd=%h, want 0 0 0 000",
               b3.busy, b3.done, b3.overflow, b3.bcd);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (b3.done || b3.busy) ndone++;
    end
    checks++;
    if (ndone != 0 || b3.bcd !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_after: busy/done seen %0d times bcd=%h, want 0 times 000",
               ndone, b3.bcd);
    end
    model3 = '0;
    model2 = '0;
  endtask

  task automatic test_blanking();
    bit ok;
    logic [6:0] e;
    logic [11:0] vals[2];
    vals[0] = 12'h007;
    vals[1] = 12'h000;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int t = 0; t < 2; t++) begin
      convert(vals[t][7:0], 8'd0, 8'd0, vals[t], 1'b0, vals[t][7:0], 1'b0, "conv_blank");
      wait_slot0(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL blank_sync[%0d]: digit 0 slot not seen, sel=%b", t, b3.dig_sel);
      end
      for (int k = 0; k < 12; k++) begin
        e = exp_scan(vals[t], k / 4);
        checks++;
        if ({b3.dig_sel, b3.dig_val} !== e) begin
          errors++;
          $display("FAIL blank_%h[%0d]: sel=%b val=%h, want sel=%b val=%h",
                   vals[t], k, b3.dig_sel, b3.dig_val, e[6:4], e[3:0]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b1, 8'd9, 8'd0, 8'd0);
    test_reset();
    test_convert();
    test_overflow();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_blanking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_bcd_scan_display.md
Name: bin_bcd_scan_display

Overview:
Parametrised, clocked binary-to-BCD display driver. Picks one of three binary sources by nonzero priority and converts it sequentially to DIGITS BCD digits using shift-and-add-3 (double-dabble). Time-multiplexes the digits onto one 4-bit digit bus with a one-hot digit select. Sits between the datapath/counters and the board's 7-segment decoder, replacing the fixed two-digit tens/ones split.

Parameters:
BIN_W, 8, width of each binary source (1..16)
DIGITS, 3, number of BCD digits produced and scanned (1..5)
SCAN_DIV, 50000, clock cycles per digit scan slot (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  display enable; 0 blanks the scan outputs
start  input  1  one-cycle request to capture and convert
src_x  input  BIN_W  highest-priority source
src_y  input  BIN_W  second-priority source
src_z  input  BIN_W  fallback source
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when bcd updated
overflow  output  1  last captured value exceeded 10^DIGITS-1
bcd  output  4*DIGITS  converted digits, digit 0 (ones) in [3:0]
dig_sel  output  DIGITS  one-hot active-high digit select
dig_val  output  4  BCD value of the selected digit

Behaviour:
- One clock; reset synchronous, active-high. Reset: state IDLE, busy=0, done=0, overflow=0, bcd=0, dig_sel=0, dig_val=0, prescaler=0, digit index=0.
- Reset has priority over every other input. Reset mid-conversion aborts it and leaves bcd=0.
- Source select, evaluated only on the capture edge:
  - src_x if src_x!=0;
  - else src_y if src_y!=0;
  - else src_z.
- FSM states:
  - IDLE: start=1 at edge 0 captures the selected value into the shift register, clears the BCD accumulator and moves to SHIFT. busy=1 from edge 0.
  - SHIFT: one bit per cycle, MSB first, at edges 1..BIN_W. Before each shift, every accumulator nibble >=5 gets +3. The accumulator is DIGITS+1 nibbles wide so that overflow is detectable. After BIN_W shifts, go to DONE.
  - DONE: at edge BIN_W+1, bcd and overflow register, done=1 for exactly one cycle, busy=0, return to IDLE. Latency from start to done is BIN_W+1 cycles.
- Overflow: if the extra top nibble is nonzero, overflow=1 and bcd saturates to all 9s. Otherwise overflow=0.
- bcd holds its previous value throughout a conversion; it changes only on the DONE edge.
- start while busy is ignored, not queued. Sources may change freely after the capture edge.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. On each wrap, the digit index advances 0..DIGITS-1 and wraps to 0.
  - Prescaler and index run regardless of en. SCAN_DIV=1 advances the index every cycle.
- Scan outputs, registered (one cycle after index/bcd change):
  - en=1: dig_sel = one-hot(index), dig_val = bcd nibble[index].
  - en=0: dig_sel=0, dig_val=0, effective on the next edge.
- DIGITS=1: dig_sel is constant 1 when en=1.

Optional Feature:
- Macro BCD_LEADING_ZERO_BLANK_EN.
- Defined: a digit above the most significant nonzero digit is blanked while selected: dig_sel=0 and dig_val=4'hF. Digit 0 is never blanked, so value 0 shows a single "0". Blanking is computed from the registered bcd.
- Undefined: all digits are always shown, including leading zeros.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the FSM enum (IDLE, SHIFT, DONE);
  - NIB_W=4;
  - BLANK_NIB=4'hF;
  - a constant function pow10(n) for parameter sanity checks.
- One natural sub-module: bcd_scan_mux (prescaler, digit index, registered select/value mux, optional blanking). The converter FSM stays in the top level.

Test Plan:
1. Bench config BIN_W=8, DIGITS=3, SCAN_DIV=4. Hold rst=1 for 3 cycles with start=1 -> busy=0, done=0, bcd=0, dig_sel=0, dig_val=0 throughout; no conversion after release until a new start.
2. x=0, y=57, z=3, start pulse -> busy high for 9 cycles, done pulse at edge 9, bcd=12'h057, overflow=0. Repeat with x=200 -> bcd=12'h200.
3. x=255 with DIGITS=2 -> overflow=1, bcd=8'h99. With DIGITS=3 -> bcd=12'h255, overflow=0. x=y=0, z=0 -> bcd=0.
4. bcd=12'h123, en=1 -> dig_sel sequence 001, 010, 100, 001, each held 4 cycles, with dig_val 3, 2, 1, 3. Drop en -> both outputs 0 on the next edge.
5. Second start issued 3 cycles into a conversion -> ignored; exactly one done pulse; bcd reflects the first capture. Reset asserted mid-SHIFT -> bcd=0, busy=0, no done.
6. Macro defined, bcd=12'h007 -> digits 1 and 2 slots give dig_sel=0, dig_val=F; digit 0 shows 7. Value 0 -> only digit 0 shows 0.
